mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 156 +++++++++++++++
 tb/tb_mem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Behavioural memory responder for a cache under test. It accepts one request
// at a time, answers after a fixed LATENCY, returns whole 64-bit lines on reads
// and performs byte-masked 32-bit writes into one half of a line.
module mem_responder #(
    parameter int LINE_ADDR_BIT = 10,
    parameter int LATENCY       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_write_i,
    input  logic [31:0] mem_write_data_i,
    input  logic [3:0]  mem_write_mask_i,
    output logic        mem_rep_o,
    output logic [63:0] mem_rep_data_o,
    output logic        busy_o
);

    localparam int          LINES = 1 << LINE_ADDR_BIT;
    localparam logic [3:0]  LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        REPLY
    } state_t;

    state_t state;
    state_t state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       accept;

    // Latched request; only meaningful from acceptance until REPLY ends.
    logic [LINE_ADDR_BIT-1:0] index_q;
    logic                     half_q;
    logic                     write_q;
    logic [63:0]              wdata_q;
    logic [3:0]               wmask_q;

    // Byte-reversed forms: the first byte of the word on the bus (data[31:24])
    // lands at the lowest line byte, so reversing once at capture lets the
    // store use straight lane indexing.
    logic [31:0] data_rev;
    logic [3:0]  mask_rev;
    logic [7:0]  lane_en;

    // Request fields selected for the edge that enters REPLY; with LATENCY=1
    // that edge is the acceptance edge, so the live inputs must be used.
    logic [LINE_ADDR_BIT-1:0] sel_index;
    logic                     sel_write;
    logic                     enter_reply;

    logic [63:0] store [0:LINES-1];

    // Address bits that do not take part in line selection.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr_i[31:LINE_ADDR_BIT+3], mem_addr_i[1:0]};

    assign accept = (state == IDLE) && mem_req_i;

    // State register and latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, counter and handshake outputs.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mem_rep_o  = 1'b0;
        busy_o     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_i) begin
                    cnt_next   = LOAD;
                    state_next = (LATENCY > 1) ? WAIT : REPLY;
                end
            end
            WAIT: begin
                busy_o = 1'b1;
                if (cnt <= 4'd1) begin
                    cnt_next   = '0;
                    state_next = REPLY;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            REPLY: begin
                busy_o     = 1'b1;
                mem_rep_o  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte reordering of the incoming word and mask, and lane enables of the
    // latched write.
    always_comb begin
        data_rev = {mem_write_data_i[7:0], mem_write_data_i[15:8],
                    mem_write_data_i[23:16], mem_write_data_i[31:24]};
        mask_rev = {mem_write_mask_i[0], mem_write_mask_i[1],
                    mem_write_mask_i[2], mem_write_mask_i[3]};
        lane_en  = half_q ? {wmask_q, 4'b0000} : {4'b0000, wmask_q};
    end

    // Selection of the request that is about to enter REPLY.
    always_comb begin
        sel_index   = (state == IDLE) ? mem_addr_i[LINE_ADDR_BIT+2:3] : index_q;
        sel_write   = (state == IDLE) ? mem_write_i : write_q;
        enter_reply = (state_next == REPLY) && (state != REPLY);
    end

    // Capture of the request fields on acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            index_q <= mem_addr_i[LINE_ADDR_BIT+2:3];
            half_q  <= mem_addr_i[2];
            write_q <= mem_write_i;
            wdata_q <= {data_rev, data_rev};
            wmask_q <= mask_rev;
        end
    end

    // Read reply data, loaded on the edge entering REPLY and held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rep_data_o <= '0;
        end else if (enter_reply && !sel_write) begin
            mem_rep_data_o <= store[sel_index];
        end
    end

    // Line store; a write commits on the edge that leaves REPLY unless reset
    // aborts it. The store itself is never reset.
    always_ff @(posedge clk) begin
        if (!rst && (state == REPLY) && write_q) begin
            for (int k = 0; k < 8; k++) begin
                if (lane_en[k]) begin
                    store[index_q][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance at LATENCY=4, one at
// LATENCY=1, each with its own expectation queue and reply monitor.
module tb_mem_responder;

    localparam int L0 = 4;
    localparam int L1 = 1;

    localparam logic [63:0] LINE2_FULL = 64'h88776655_DDCCBBAA;
    localparam logic [63:0] LINE2_PART = 64'h44776611_DDCCBBAA;
    localparam logic [63:0] LINE3      = 64'h08070605_04030201;
    localparam logic [63:0] LINE0_WRAP = 64'h78563412_0DF0FECA;

    logic clk = 1'b0;
    logic rst;

    logic        req0, wr0, rep0, busy0;
    logic [31:0] addr0, wd0;
    logic [3:0]  mask0;
    logic [63:0] rdata0;

    logic        req1, wr1, rep1, busy1;
    logic [31:0] addr1, wd1;
    logic [3:0]  mask1;
    logic [63:0] rdata1;

    mem_responder #(.LINE_ADDR_BIT(10), .LATENCY(L0)) dut (
        .clk(clk), .rst(rst), .mem_req_i(req0), .mem_addr_i(addr0),
        .mem_write_i(wr0), .mem_write_data_i(wd0), .mem_write_mask_i(mask0),
        .mem_rep_o(rep0), .mem_rep_data_o(rdata0), .busy_o(busy0)
    );

    mem_responder #(.LINE_ADDR_BIT(10), .LATENCY(L1)) dut1 (
        .clk(clk), .rst(rst), .mem_req_i(req1), .mem_addr_i(addr1),
        .mem_write_i(wr1), .mem_write_data_i(wd1), .mem_write_mask_i(mask1),
        .mem_rep_o(rep1), .mem_rep_data_o(rdata1), .busy_o(busy1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [63:0] data;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic [63:0] last0 = '0;
    logic [63:0] last1 = '0;
    bit mon_en = 1'b0;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Reply monitor, LATENCY=4 instance.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rep0) begin
            if (q0.size() == 0) begin
                chk(1'b0, "L4_unexpected_reply", {63'd0, rep0}, 64'd0);
            end else begin
                e = q0.pop_front();
                chk(cyc == e.cyc, {e.tag, "_latency"}, 64'(cyc), 64'(e.cyc));
                chk(rdata0 == e.data, {e.tag, "_data"}, rdata0, e.data);
            end
        end
    end

    // Reply monitor, LATENCY=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rep1) begin
            if (q1.size() == 0) begin
                chk(1'b0, "L1_unexpected_reply", {63'd0, rep1}, 64'd0);
            end else begin
                e = q1.pop_front();
                chk(cyc == e.cyc, {e.tag, "_latency"}, 64'(cyc), 64'(e.cyc));
                chk(rdata1 == e.data, {e.tag, "_data"}, rdata1, e.data);
            end
        end
    end

    task automatic wait_idle0(input string tag);
        for (int i = 0; i < 40 && busy0; i++) @(negedge clk);
        if (busy0) chk(1'b0, {tag, "_busy_timeout"}, {63'd0, busy0}, 64'd0);
    endtask

    task automatic wait_idle1(input string tag);
        for (int i = 0; i < 40 && busy1; i++) @(negedge clk);
        if (busy1) chk(1'b0, {tag, "_busy_timeout"}, {63'd0, busy1}, 64'd0);
    endtask

    // Issue one request to the LATENCY=4 instance; starts and ends at a negedge.
    task automatic req0_t(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic [63:0] rd_exp, input string tag);
        exp_t e;
        wait_idle0(tag);
        req0 = 1'b1; wr0 = wr; addr0 = a; wd0 = d; mask0 = m;
        if (!wr) last0 = rd_exp;
        e.data = last0; e.cyc = cyc + L0; e.tag = tag;
        q0.push_back(e);
        @(negedge clk);
        req0 = 1'b0; wr0 = 1'b0;
    endtask

    task automatic req1_t(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic [63:0] rd_exp, input string tag);
        exp_t e;
        wait_idle1(tag);
        req1 = 1'b1; wr1 = wr; addr1 = a; wd1 = d; mask1 = m;
        if (!wr) last1 = rd_exp;
        e.data = last1; e.cyc = cyc + L1; e.tag = tag;
        q1.push_back(e);
        @(negedge clk);
        req1 = 1'b0; wr1 = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        req0 = 0; wr0 = 0; addr0 = 0; wd0 = 0; mask0 = 0;
        req1 = 0; wr1 = 0; addr1 = 0; wd1 = 0; mask1 = 0;
        repeat (3) @(negedge clk);
        chk(rep0 == 1'b0,    "reset_rep_L4",   {63'd0, rep0},  64'd0);
        chk(busy0 == 1'b0,   "reset_busy_L4",  {63'd0, busy0}, 64'd0);
        chk(rdata0 == 64'd0, "reset_data_L4",  rdata0,         64'd0);
        chk(rep1 == 1'b0,    "reset_rep_L1",   {63'd0, rep1},  64'd0);
        chk(busy1 == 1'b0,   "reset_busy_L1",  {63'd0, busy1}, 64'd0);
        chk(rdata1 == 64'd0, "reset_data_L1",  rdata1,         64'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Full-line write and read-back, then a masked upper-half write.
        req0_t(1'b1, 32'h10, 32'hAABBCCDD, 4'hF, 64'd0, "wr_line2_lo");
        req0_t(1'b1, 32'h14, 32'h55667788, 4'hF, 64'd0, "wr_line2_hi");
        req0_t(1'b0, 32'h10, 32'h0, 4'h0, LINE2_FULL, "rd_line2");
        req0_t(1'b1, 32'h14, 32'h11223344, 4'b1001, 64'd0, "wr_partial");
        req0_t(1'b0, 32'h17, 32'h0, 4'h0, LINE2_PART, "rd_partial");
        req0_t(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 64'd0, "wr_mask0");
        req0_t(1'b0, 32'h10, 32'h0, 4'h0, LINE2_PART, "rd_after_mask0");
        req0_t(1'b1, 32'h18, 32'h01020304, 4'hF, 64'd0, "wr_line3_lo");
        req0_t(1'b1, 32'h1C, 32'h05060708, 4'hF, 64'd0, "wr_line3_hi");

        // Request held high through busy with garbage writes in the shadow.
        wait_idle0("held");
        req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h10;
        last0 = LINE2_PART;
        e.data = LINE2_PART; e.cyc = cyc + L0; e.tag = "held_rd1";
        q0.push_back(e);
        for (int k = 1; k <= L0; k++) begin
            @(negedge clk);
            chk(busy0 == 1'b1, "held_busy_first", {63'd0, busy0}, 64'd1);
            wr0 = 1'b1; addr0 = 32'h10; wd0 = 32'hDEAD0000 | 32'(k); mask0 = 4'hF;
        end
        @(negedge clk);
        chk(busy0 == 1'b0, "held_idle_gap", {63'd0, busy0}, 64'd0);
        wr0 = 1'b0; addr0 = 32'h18;
        last0 = LINE3;
        e.data = LINE3; e.cyc = cyc + L0; e.tag = "held_rd2";
        q0.push_back(e);
        for (int k = 1; k <= L0; k++) begin
            @(negedge clk);
            chk(busy0 == 1'b1, "held_busy_second", {63'd0, busy0}, 64'd1);
            wr0 = 1'b1; addr0 = 32'h18; wd0 = 32'hBEEF0000 | 32'(k); mask0 = 4'hF;
            if (k == L0) begin
                req0 = 1'b0; wr0 = 1'b0;
            end
        end
        req0_t(1'b0, 32'h10, 32'h0, 4'h0, LINE2_PART, "rd_line2_after_held");

        // Reset two edges after accepting a write aborts it.
        wait_idle0("abort");
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h18; wd0 = 32'hFFFFFFFF; mask0 = 4'hF;
        @(negedge clk);
        req0 = 1'b0; wr0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk(busy0 == 1'b0,   "abort_busy",  {63'd0, busy0}, 64'd0);
        chk(rep0 == 1'b0,    "abort_rep",   {63'd0, rep0},  64'd0);
        chk(rdata0 == 64'd0, "abort_data",  rdata0,         64'd0);
        chk(rdata1 == 64'd0, "abort_data_L1", rdata1,       64'd0);
        last0 = '0;
        last1 = '0;
        rst = 1'b0;
        req0_t(1'b0, 32'h18, 32'h0, 4'h0, LINE3, "rd_line3_after_abort");

        // Index wrap-around.
        req0_t(1'b1, 32'h2000, 32'hCAFEF00D, 4'hF, 64'd0, "wr_wrap_lo");
        req0_t(1'b1, 32'h2004, 32'h12345678, 4'hF, 64'd0, "wr_wrap_hi");
        req0_t(1'b0, 32'h0, 32'h0, 4'h0, LINE0_WRAP, "rd_wrap");

        // LATENCY=1 instance: wrap-around, one-cycle busy, back-to-back order.
        req1_t(1'b1, 32'h2000, 32'hCAFEF00D, 4'hF, 64'd0, "l1_wr_wrap_lo");
        req1_t(1'b1, 32'h2004, 32'h12345678, 4'hF, 64'd0, "l1_wr_wrap_hi");
        wait_idle1("l1_rd");
        req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h0;
        last1 = LINE0_WRAP;
        e.data = LINE0_WRAP; e.cyc = cyc + L1; e.tag = "l1_rd_wrap";
        q1.push_back(e);
        @(negedge clk);
        req1 = 1'b0;
        chk(busy1 == 1'b1, "l1_busy_reply", {63'd0, busy1}, 64'd1);
        @(negedge clk);
        chk(busy1 == 1'b0, "l1_busy_one_cycle", {63'd0, busy1}, 64'd0);
        req1_t(1'b1, 32'h8, 32'h0A0B0C0D, 4'b0110, 64'd0, "l1_wr_line1");
        req1_t(1'b1, 32'hC, 32'h00000000, 4'hF, 64'd0, "l1_wr_line1_hi");
        req1_t(1'b1, 32'h8, 32'h11111111, 4'b1001, 64'd0, "l1_wr_line1_ends");
        req1_t(1'b0, 32'h8, 32'h0, 4'h0, 64'h00000000_110C0B11, "l1_rd_line1");

        for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        chk(q0.size() == 0 && q1.size() == 0, "drain_pending",
            64'(q0.size() + q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
